// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - UART 8N1 receive deserializer, 4x oversampled; UART_RX_PARITY_EN adds even parity
module uart_rx_deser #(
    parameter int unsigned CLK_DIV = 108
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_rx,
    output logic       uart_rx_byte_en,
    output logic [7:0] uart_rx_byte,
    output logic       uart_rx_frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BRK
    } state_t;

    state_t      state, state_d;
    logic        rx_m, rx_s;
    logic [15:0] div_cnt;
    logic        tick;
    logic [1:0]  sub;
    logic        s1, s2;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        maj, bit_end;
    logic        bit_done, emit_byte, emit_err, enter_data;
`ifdef UART_RX_PARITY_EN
    logic        par_err;
    logic        par_check;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    assign tick = (div_cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 16'd1;
    end

    // s3 is the live rx_s on the fourth tick; s0 is never stored.
    assign maj     = (s1 & s2) | (s1 & rx_s) | (s2 & rx_s);
    assign bit_end = tick && (sub == 2'd3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        bit_done   = 1'b0;
        emit_byte  = 1'b0;
        emit_err   = 1'b0;
        enter_data = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_check  = 1'b0;
`endif
        case (state)
            ST_IDLE: if (tick && !rx_s) state_d = ST_START;
            ST_START: if (bit_end) begin
                if (maj) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_DATA;
                    enter_data = 1'b1;
                end
            end
            ST_DATA: if (bit_end) begin
                bit_done = 1'b1;
                if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (bit_end) begin
                par_check = 1'b1;
                state_d   = ST_STOP;
            end
`endif
            ST_STOP: if (bit_end) begin
                if (maj) begin
                    state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                    emit_byte = !par_err;
                    emit_err  = par_err;
`else
                    emit_byte = 1'b1;
`endif
                end else begin
                    state_d  = ST_BRK;
                    emit_err = 1'b1;
                end
            end
            ST_BRK: if (tick && rx_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The tick that detects the start edge is s0, so sub resumes at 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sub <= 2'd0;
            s1  <= 1'b0;
            s2  <= 1'b0;
        end else if (tick) begin
            if (state == ST_IDLE || state == ST_BRK)
                sub <= (state == ST_IDLE && !rx_s) ? 2'd1 : 2'd0;
            else
                sub <= sub + 2'd1;
            if (sub == 2'd1) s1 <= rx_s;
            if (sub == 2'd2) s2 <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx   <= 3'd0;
            shreg <= 8'h00;
        end else if (enter_data) begin
            idx <= 3'd0;
        end else if (bit_done) begin
            shreg[idx] <= maj;
            idx        <= idx + 3'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          par_err <= 1'b0;
        else if (enter_data) par_err <= 1'b0;
        else if (par_check)  par_err <= maj ^ (^shreg);
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            uart_rx_byte_en   <= 1'b0;
            uart_rx_byte      <= 8'h00;
            uart_rx_frame_err <= 1'b0;
        end else begin
            uart_rx_byte_en   <= emit_byte;
            uart_rx_frame_err <= emit_err;
            if (emit_byte) uart_rx_byte <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - directed bench for uart_rx_deser at CLK_DIV=4 (16 clk per bit)
module tb_uart_rx_deser;

    localparam int CLK_DIV = 4;
    localparam int BIT     = 4 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME   = 11;
`else
    localparam int FRAME   = 10;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       uart_rx = 1'b1;
    logic       uart_rx_byte_en;
    logic [7:0] uart_rx_byte;
    logic       uart_rx_frame_err;

    int total = 0;
    int bad   = 0;

    uart_rx_deser #(.CLK_DIV(CLK_DIV)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .uart_rx           (uart_rx),
        .uart_rx_byte_en   (uart_rx_byte_en),
        .uart_rx_byte      (uart_rx_byte),
        .uart_rx_frame_err (uart_rx_frame_err)
    );

    always #5 clk = ~clk;

    logic [7:0] log_byte[$];
    int         log_cyc[$];
    int         n_err = 0;
    int         viol  = 0;
    int         cyc   = 0;
    logic       prev_en = 1'b0, prev_err = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (uart_rx_byte_en) begin
            log_byte.push_back(uart_rx_byte);
            log_cyc.push_back(cyc);
        end
        if (uart_rx_frame_err) n_err = n_err + 1;
        if (uart_rx_byte_en && uart_rx_frame_err) viol = viol + 1;
        if ((uart_rx_byte_en && prev_en) || (uart_rx_frame_err && prev_err)) viol = viol + 1;
        prev_en  = uart_rx_byte_en;
        prev_err = uart_rx_frame_err;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        wait_clks(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
    endtask

    task automatic test_reset();
        wait_clks(3);
        total++; if (uart_rx_byte_en !== 1'b0) begin bad++; $display("FAIL reset_byte_en got=%b want=0", uart_rx_byte_en); end
        total++; if (uart_rx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h want=00", uart_rx_byte); end
        total++; if (uart_rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", uart_rx_frame_err); end
        rstn = 1'b1;
        wait_clks(2 * BIT);
    endtask

    task automatic test_single();
        int b0 = log_byte.size();
        int e0 = n_err;
        send_frame(8'h41, 1'b0, 1'b1);
        send_bit(1'b1);
        total++; if (log_byte.size() - b0 !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", log_byte.size() - b0); end
        total++; if (log_byte[b0] !== 8'h41) begin bad++; $display("FAIL single_byte got=%h want=41", log_byte[b0]); end
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL single_err got=%0d want=0", n_err - e0); end
    endtask

    task automatic test_back_to_back();
        int b0 = log_byte.size();
        int e0 = n_err;
        int gap;
        send_frame(8'h33, 1'b0, 1'b1);
        send_frame(8'h41, 1'b0, 1'b1);
        send_frame(8'h0A, 1'b0, 1'b1);
        send_bit(1'b1);
        total++; if (log_byte.size() - b0 !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", log_byte.size() - b0); end
        total++; if (log_byte[b0] !== 8'h33) begin bad++; $display("FAIL b2b_byte0 got=%h want=33", log_byte[b0]); end
        total++; if (log_byte[b0+1] !== 8'h41) begin bad++; $display("FAIL b2b_byte1 got=%h want=41", log_byte[b0+1]); end
        total++; if (log_byte[b0+2] !== 8'h0A) begin bad++; $display("FAIL b2b_byte2 got=%h want=0a", log_byte[b0+2]); end
        for (int i = 0; i < 2; i++) begin
            gap = log_cyc[b0+i+1] - log_cyc[b0+i];
            total++;
            if (gap < FRAME * BIT - 4 || gap > FRAME * BIT + 4) begin
                bad++; $display("FAIL b2b_spacing%0d got=%0d want=%0d+-4", i, gap, FRAME * BIT);
            end
        end
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL b2b_err got=%0d want=0", n_err - e0); end
    endtask

    task automatic test_glitch();
        int b0 = log_byte.size();
        int e0 = n_err;
        uart_rx = 1'b0;
        wait_clks(4);
        uart_rx = 1'b1;
        wait_clks(3 * BIT);
        total++; if (log_byte.size() - b0 !== 0) begin bad++; $display("FAIL glitch_byte_en got=%0d want=0", log_byte.size() - b0); end
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL glitch_err got=%0d want=0", n_err - e0); end
        send_frame(8'h55, 1'b0, 1'b1);
        send_bit(1'b1);
        total++; if (log_byte.size() - b0 !== 1) begin bad++; $display("FAIL glitch_next_count got=%0d want=1", log_byte.size() - b0); end
        total++; if (log_byte[b0] !== 8'h55) begin bad++; $display("FAIL glitch_next_byte got=%h want=55", log_byte[b0]); end
    endtask

    task automatic test_break();
        int b0 = log_byte.size();
        int e0 = n_err;
        send_frame(8'hA5, 1'b0, 1'b0);
        uart_rx = 1'b0;
        wait_clks(40 * BIT);
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL break_err_count got=%0d want=1", n_err - e0); end
        total++; if (log_byte.size() - b0 !== 0) begin bad++; $display("FAIL break_byte_en got=%0d want=0", log_byte.size() - b0); end
        total++; if (uart_rx_byte !== 8'h55) begin bad++; $display("FAIL break_byte_held got=%h want=55", uart_rx_byte); end
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        send_bit(1'b1);
        total++; if (log_byte.size() - b0 !== 1) begin bad++; $display("FAIL break_next_count got=%0d want=1", log_byte.size() - b0); end
        total++; if (uart_rx_byte !== 8'h5A) begin bad++; $display("FAIL break_next_byte got=%h want=5a", uart_rx_byte); end
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL break_err_after got=%0d want=1", n_err - e0); end
    endtask

    task automatic test_reset_mid_frame();
        int b0 = log_byte.size();
        int e0 = n_err;
        int errs = 0;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rstn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_rx_byte_en !== 1'b0 || uart_rx_frame_err !== 1'b0 || uart_rx_byte !== 8'h00) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL midreset_outputs got=%0d nonzero samples want=0", errs); end
        wait_clks(1);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        total++; if (log_byte.size() - b0 !== 0) begin bad++; $display("FAIL midreset_aborted got=%0d want=0", log_byte.size() - b0); end
        send_frame(8'h12, 1'b0, 1'b1);
        send_bit(1'b1);
        total++; if (log_byte.size() - b0 !== 1) begin bad++; $display("FAIL midreset_count got=%0d want=1", log_byte.size() - b0); end
        total++; if (log_byte[b0] !== 8'h12) begin bad++; $display("FAIL midreset_byte got=%h want=12", log_byte[b0]); end
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL midreset_err got=%0d want=0", n_err - e0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int b0 = log_byte.size();
        int e0 = n_err;
        send_frame(8'h03, 1'b0, 1'b1);
        send_bit(1'b1);
        total++; if (log_byte.size() - b0 !== 1) begin bad++; $display("FAIL parity_ok_count got=%0d want=1", log_byte.size() - b0); end
        total++; if (log_byte[b0] !== 8'h03) begin bad++; $display("FAIL parity_ok_byte got=%h want=03", log_byte[b0]); end
        send_frame(8'h03, 1'b1, 1'b1);
        send_bit(1'b1);
        total++; if (log_byte.size() - b0 !== 1) begin bad++; $display("FAIL parity_bad_byte_en got=%0d want=1", log_byte.size() - b0); end
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL parity_bad_err got=%0d want=1", n_err - e0); end
    endtask
`endif

    task automatic test_pulse_rules();
        total++; if (viol !== 0) begin bad++; $display("FAIL pulse_rules got=%0d violations want=0", viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_pulse_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
